// File: rtl/ex_muldiv_sequencer.sv
// Iterative RV32M multiply/divide sequencer for the EXECUTE stage.
// Shift-add multiply or restoring divide over XLEN cycles, then sign and special-case fix-up.
//
// state  | meaning
// IDLE   | waiting for start_i
// CALC   | one multiply/divide step per cycle, XLEN steps
// FIX    | sign correction, special cases, result register load
// DONE   | done_o high for this cycle; a new start may be accepted
module ex_muldiv_sequencer #(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            reset_i,
  input  logic            start_i,
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] operand1_i,
  input  logic [XLEN-1:0] operand2_i,
  input  logic            flush_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o
);

  localparam int CW = $clog2(XLEN);
  localparam logic [CW-1:0] LAST = CW'(XLEN - 1);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

  state_t          state;
  logic [CW-1:0]   count;
  logic [2:0]      op_q;
  logic            sign_q;
  logic            div_zero_q;
  logic            ovf_q;
  logic [XLEN-1:0] op1_q;
  logic [XLEN-1:0] opnd_q;
  logic [XLEN-1:0] acc_hi;
  logic [XLEN-1:0] acc_lo;

  logic            accept;
  logic            signed_a, signed_b, a_neg, b_neg, res_neg, ovf_in;
  logic [XLEN-1:0] abs_a, abs_b;
  logic [XLEN:0]   mul_sum;
  logic [XLEN:0]   div_shift;
  logic [XLEN:0]   div_diff;
  logic [2*XLEN-1:0] prod, prod_fix;
  logic [XLEN-1:0] quot_fix, rem_fix, fix_result;

  assign accept = start_i & ~flush_i & ((state == S_IDLE) | (state == S_DONE));
  assign busy_o = accept | (state == S_CALC) | (state == S_FIX);

  // Operands are converted to magnitudes up front; the result sign is restored in FIX.
  always_comb begin
    signed_a = (op_i == OP_MULH) | (op_i == OP_MULHSU) | (op_i == OP_DIV) | (op_i == OP_REM);
    signed_b = (op_i == OP_MULH) | (op_i == OP_DIV) | (op_i == OP_REM);
    a_neg    = signed_a & operand1_i[XLEN-1];
    b_neg    = signed_b & operand2_i[XLEN-1];
    abs_a    = a_neg ? -operand1_i : operand1_i;
    abs_b    = b_neg ? -operand2_i : operand2_i;
    res_neg  = (op_i == OP_REM) ? a_neg : (a_neg ^ b_neg);
    ovf_in   = ((op_i == OP_DIV) | (op_i == OP_REM)) &
               (operand1_i == MIN_NEG) & (operand2_i == '1);
  end

  // acc_lo holds the multiplier (shifting out) or dividend/quotient (shifting through).
  always_comb begin
    mul_sum   = {1'b0, acc_hi} + {1'b0, (acc_lo[0] ? opnd_q : '0)};
    div_shift = {acc_hi, acc_lo[XLEN-1]};
    div_diff  = div_shift - {1'b0, opnd_q};
  end

  always_comb begin
    prod     = {acc_hi, acc_lo};
    prod_fix = sign_q ? -prod : prod;
    quot_fix = sign_q ? -acc_lo : acc_lo;
    rem_fix  = sign_q ? -acc_hi : acc_hi;
    fix_result = '0;
    case (op_q)
      OP_MUL:                        fix_result = prod_fix[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU:  fix_result = prod_fix[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU: begin
        if (div_zero_q)     fix_result = '1;
        else if (ovf_q)     fix_result = MIN_NEG;
        else                fix_result = quot_fix;
      end
      OP_REM, OP_REMU: begin
        if (div_zero_q)     fix_result = op1_q;
        else if (ovf_q)     fix_result = '0;
        else                fix_result = rem_fix;
      end
      default:              fix_result = '0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state      <= S_IDLE;
      count      <= '0;
      op_q       <= '0;
      sign_q     <= 1'b0;
      div_zero_q <= 1'b0;
      ovf_q      <= 1'b0;
      op1_q      <= '0;
      opnd_q     <= '0;
      acc_hi     <= '0;
      acc_lo     <= '0;
      done_o     <= 1'b0;
      result_o   <= '0;
    end else begin
      done_o <= 1'b0;
      case (state)
        S_IDLE, S_DONE: begin
          if (accept) begin
            op_q       <= op_i;
            sign_q     <= res_neg;
            div_zero_q <= (operand2_i == '0);
            ovf_q      <= ovf_in;
            op1_q      <= operand1_i;
            opnd_q     <= abs_b;
            acc_hi     <= '0;
            acc_lo     <= abs_a;
            count      <= '0;
            state      <= S_CALC;
          end else begin
            state <= S_IDLE;
          end
        end
        S_CALC: begin
          if (flush_i) begin
            state <= S_IDLE;
          end else begin
            if (op_q[2]) begin
              if (!div_diff[XLEN]) begin
                acc_hi <= div_diff[XLEN-1:0];
                acc_lo <= {acc_lo[XLEN-2:0], 1'b1};
              end else begin
                acc_hi <= div_shift[XLEN-1:0];
                acc_lo <= {acc_lo[XLEN-2:0], 1'b0};
              end
            end else begin
              acc_hi <= mul_sum[XLEN:1];
              acc_lo <= {mul_sum[0], acc_lo[XLEN-1:1]};
            end
            count <= count + 1'b1;
            if (count == LAST) state <= S_FIX;
          end
        end
        S_FIX: begin
          if (flush_i) begin
            state <= S_IDLE;
          end else begin
            result_o <= fix_result;
            done_o   <= 1'b1;
            state    <= S_DONE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ex_muldiv_sequencer.sv
// Directed bench for ex_muldiv_sequencer: arithmetic, special cases, latency, flush, reset.
module tb_ex_muldiv_sequencer;

  localparam logic [2:0] MUL = 3'b000, MULH = 3'b001, MULHSU = 3'b010, MULHU = 3'b011;
  localparam logic [2:0] DIV = 3'b100, DIVU = 3'b101, REM = 3'b110, REMU = 3'b111;

  logic        clk_i = 1'b0;
  logic        reset_i = 1'b1;
  logic        start_i = 1'b0;
  logic [2:0]  op_i = 3'b000;
  logic [31:0] operand1_i = '0;
  logic [31:0] operand2_i = '0;
  logic        flush_i = 1'b0;
  logic        busy_o;
  logic        done_o;
  logic [31:0] result_o;

  int n_tests = 0;
  int n_fail  = 0;

  ex_muldiv_sequencer #(.XLEN(32)) dut (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .start_i    (start_i),
    .op_i       (op_i),
    .operand1_i (operand1_i),
    .operand2_i (operand2_i),
    .flush_i    (flush_i),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .result_o   (result_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Drives a start request for one cycle; returns #1 after the accepting edge.
  task automatic start_op(input string tag, input logic [2:0] op,
                          input logic [31:0] a, input logic [31:0] b);
    @(negedge clk_i);
    start_i = 1'b1; op_i = op; operand1_i = a; operand2_i = b;
    #1 check({tag, " busy on start"}, {31'd0, busy_o}, 32'd1);
    @(posedge clk_i); #1;
    start_i = 1'b0;
  endtask

  // Runs one op and checks latency, result and busy in the done cycle; returns in DONE.
  task automatic run_op(input string tag, input logic [2:0] op,
                        input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
    int cyc;
    start_op(tag, op, a, b);
    cyc = 1;
    while (!done_o && cyc < 60) begin
      @(posedge clk_i); #1;
      cyc++;
    end
    check({tag, " latency"}, 32'(cyc), 32'd34);
    check({tag, " result"}, result_o, exp);
    check({tag, " busy in done"}, {31'd0, busy_o}, 32'd0);
  endtask

  task automatic watch_no_done(input string tag, input int n);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk_i); #1;
      seen |= done_o;
    end
    check({tag, " no done"}, {31'd0, seen}, 32'd0);
  endtask

  initial begin
    repeat (2) @(posedge clk_i);
    #1;
    reset_i = 1'b0;
    check("reset done", {31'd0, done_o}, 32'd0);
    check("reset busy", {31'd0, busy_o}, 32'd0);
    check("reset result", result_o, 32'd0);

    run_op("MUL 7x-3", MUL, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB);
    @(posedge clk_i); #1;
    check("done one cycle", {31'd0, done_o}, 32'd0);
    check("result held", result_o, 32'hFFFF_FFEB);

    run_op("MULH min*min", MULH, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000);
    run_op("MULHU", MULHU, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000);
    run_op("MULHSU", MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op("DIV -7/2", DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
    run_op("REM -7/2", REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
    run_op("DIVU 100/7", DIVU, 32'd100, 32'd7, 32'd14);
    run_op("REMU 100/7", REMU, 32'd100, 32'd7, 32'd2);
    run_op("DIV ovf", DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
    run_op("REM ovf", REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);
    run_op("DIV by 0", DIV, 32'h0000_1234, 32'd0, 32'hFFFF_FFFF);
    run_op("REMU by 0", REMU, 32'h0000_1234, 32'd0, 32'h0000_1234);

    // Flush at cycle 10 of a DIV, with a competing start on the same cycle.
    start_op("flush DIV", DIV, 32'd1000, 32'd3);
    repeat (9) @(posedge clk_i);
    @(negedge clk_i);
    flush_i = 1'b1; start_i = 1'b1; op_i = MUL; operand1_i = 32'd2; operand2_i = 32'd3;
    @(posedge clk_i); #1;
    check("flush busy low", {31'd0, busy_o}, 32'd0);
    flush_i = 1'b0; start_i = 1'b0;
    watch_no_done("flush", 40);
    check("flush result kept", result_o, 32'h0000_1234);

    // Start with flush in IDLE is dropped.
    @(negedge clk_i);
    flush_i = 1'b1; start_i = 1'b1;
    #1 check("idle flush+start busy", {31'd0, busy_o}, 32'd0);
    @(posedge clk_i); #1;
    flush_i = 1'b0; start_i = 1'b0;
    watch_no_done("idle flush+start", 40);

    // Back-to-back: second start issued during the DONE cycle.
    run_op("b2b first", MUL, 32'd6, 32'd7, 32'd42);
    run_op("b2b second", DIVU, 32'd42, 32'd5, 32'd8);

    // Reset mid-operation.
    start_op("reset mid", MUL, 32'd3, 32'd5);
    repeat (19) @(posedge clk_i);
    @(negedge clk_i);
    reset_i = 1'b1;
    @(posedge clk_i); #1;
    reset_i = 1'b0;
    check("mid reset result", result_o, 32'd0);
    check("mid reset busy", {31'd0, busy_o}, 32'd0);
    watch_no_done("mid reset", 40);

    run_op("after reset", REM, 32'd17, 32'hFFFF_FFFB, 32'd2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
